// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: MDU latency defaults,
// counter widths and the MDU FSM state encoding.
package pipe_ctrl_pkg;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned MD_CNT_W        = 4;
  localparam int unsigned STALL_CNT_W     = 32;
  localparam int unsigned REQ_CNT_W       = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/pipe_ctrl_md_busy_timer.sv
// MDU occupancy tracker: IDLE/BUSY FSM plus a countdown of the remaining
// multiply/divide cycles. Start is expected to be pre-qualified by the caller.
module md_busy_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                div,
  output logic                busy,
  output logic [MD_CNT_W-1:0] md_cnt
);

  localparam logic [MD_CNT_W-1:0] MULT_LD = MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_LD  = MD_CNT_W'(DIV_CYCLES);

  md_state_e           state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic [MD_CNT_W-1:0] ld_val;

  // State and countdown registers; reset aborts any countdown in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: load on start from IDLE, count down in BUSY, leave BUSY as the count hits 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ld_val  = div ? DIV_LD : MULT_LD;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = ld_val;
          if (ld_val != '0) state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q <= MD_CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - MD_CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy   = (state_q == BUSY);
  assign md_cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/exception priority controller with MDU busy tracking.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined;
// otherwise stall_cnt and req_cnt read constant 0.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hz_stall,
  input  logic                   D_md_use,
  input  logic                   E_md_start,
  input  logic                   E_md_div,
  input  logic                   D_eret,
  input  logic                   M_exc_req,
  output logic                   PC_WrEn,
  output logic                   FD_WrEn,
  output logic                   FD_flush,
  output logic                   DE_Stall,
  output logic                   Req,
  output logic                   md_busy,
  output logic [MD_CNT_W-1:0]    md_cnt,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic [REQ_CNT_W-1:0]   req_cnt
);

  logic start_ok;
  logic fsm_busy;
  logic stall;

  assign Req      = M_exc_req;
  assign start_ok = E_md_start & ~Req;

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (start_ok),
    .div    (E_md_div),
    .busy   (fsm_busy),
    .md_cnt (md_cnt)
  );

  // The FSM contribution is masked while reset is held so the MDU never looks busy in reset.
  assign md_busy = (fsm_busy & ~reset) | start_ok;
  assign stall   = hz_stall | (D_md_use & md_busy);

  // Priority: exception request, then stall, then normal flow.
  always_comb begin
    PC_WrEn  = 1'b1;
    FD_WrEn  = 1'b1;
    DE_Stall = 1'b0;
    FD_flush = 1'b0;
    if (Req) begin
      PC_WrEn  = 1'b1;
      FD_WrEn  = 1'b1;
    end else if (stall) begin
      PC_WrEn  = 1'b0;
      FD_WrEn  = 1'b0;
      DE_Stall = 1'b1;
    end else begin
      FD_flush = D_eret;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic [REQ_CNT_W-1:0]   req_cnt_q;

  // Saturating stall and exception-request cycle counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      req_cnt_q   <= '0;
    end else begin
      if (stall && !Req && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
      if (Req && (req_cnt_q != '1))             req_cnt_q   <= req_cnt_q + REQ_CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign req_cnt   = req_cnt_q;
`else
  assign stall_cnt = '0;
  assign req_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a behavioural model predicts each cycle's
// outputs when stimulus is applied; a monitor pops and compares mid-cycle.
module tb_pipe_ctrl;

  typedef struct {
    logic [3:0]  md_cnt;
    logic        md_busy;
    logic        pc_wren;
    logic        fd_wren;
    logic        fd_flush;
    logic        de_stall;
    logic        req;
    logic [31:0] stall_cnt;
    logic [15:0] req_cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, hz_stall, D_md_use, E_md_start, E_md_div, D_eret, M_exc_req;
  logic        PC_WrEn, FD_WrEn, FD_flush, DE_Stall, Req, md_busy;
  logic [3:0]  md_cnt;
  logic [31:0] stall_cnt;
  logic [15:0] req_cnt;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state
  int          m_rem = 0;
  logic [31:0] m_stall = '0;
  logic [15:0] m_req = '0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .reset(reset), .hz_stall(hz_stall), .D_md_use(D_md_use),
    .E_md_start(E_md_start), .E_md_div(E_md_div), .D_eret(D_eret), .M_exc_req(M_exc_req),
    .PC_WrEn(PC_WrEn), .FD_WrEn(FD_WrEn), .FD_flush(FD_flush), .DE_Stall(DE_Stall),
    .Req(Req), .md_busy(md_busy), .md_cnt(md_cnt), .stall_cnt(stall_cnt), .req_cnt(req_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs mid-cycle against the scoreboard entry for this cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("md_cnt",    32'(md_cnt),   32'(e.md_cnt));
      check("md_busy",   32'(md_busy),  32'(e.md_busy));
      check("PC_WrEn",   32'(PC_WrEn),  32'(e.pc_wren));
      check("FD_WrEn",   32'(FD_WrEn),  32'(e.fd_wren));
      check("FD_flush",  32'(FD_flush), 32'(e.fd_flush));
      check("DE_Stall",  32'(DE_Stall), 32'(e.de_stall));
      check("Req",       32'(Req),      32'(e.req));
      check("stall_cnt", stall_cnt,     e.stall_cnt);
      check("req_cnt",   32'(req_cnt),  32'(e.req_cnt));
    end
  end

  // Apply one cycle of inputs, predict outputs, then advance the model across the edge.
  task automatic cyc(input logic rst, input logic hz, input logic duse, input logic st,
                     input logic dv, input logic er, input logic exc);
    exp_t e;
    logic busy, stl;
    reset = rst; hz_stall = hz; D_md_use = duse; E_md_start = st;
    E_md_div = dv; D_eret = er; M_exc_req = exc;
    busy = ((m_rem != 0) && !rst) || (st && !exc);
    stl  = hz || (duse && busy);
    e.md_cnt   = 4'(m_rem);
    e.md_busy  = busy;
    e.req      = exc;
    e.pc_wren  = exc || !stl;
    e.fd_wren  = exc || !stl;
    e.de_stall = !exc && stl;
    e.fd_flush = er && !stl && !exc;
`ifdef PIPE_CTRL_PERF_EN
    e.stall_cnt = m_stall;
    e.req_cnt   = m_req;
`else
    e.stall_cnt = '0;
    e.req_cnt   = '0;
`endif
    sb.push_back(e);
    @(posedge clk);
    if (rst) begin
      m_rem = 0; m_stall = '0; m_req = '0;
    end else begin
      if (m_rem > 0)           m_rem = m_rem - 1;
      else if (st && !exc)     m_rem = dv ? 10 : 5;
      if (stl && !exc && m_stall != '1) m_stall = m_stall + 32'd1;
      if (exc && m_req != '1)           m_req   = m_req + 16'd1;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; hz_stall = 0; D_md_use = 0; E_md_start = 0; E_md_div = 0; D_eret = 0; M_exc_req = 0;
    @(posedge clk); #1;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Multiply: count 5,4,3,2,1,0
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("mult_load", 32'(md_cnt), 32'd5);
    idle(6);
    check("mult_done", 32'(md_cnt), 32'd0);

    // Divide with a dependent MDU user in D: 10 stall cycles
    cyc(0, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 11; i++) cyc(0, 0, 1, 0, 0, 0, 0);
    idle(1);

    // Exception overrides stall and blocks the MDU start
    cyc(0, 1, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("exc_no_start", 32'(md_cnt), 32'd0);

    // eret held off by a hazard, then flushes for one cycle
    cyc(0, 1, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    idle(1);

    // Reset mid-divide at md_cnt=6, then a fresh multiply
    cyc(0, 0, 0, 1, 1, 0, 0);
    idle(4);
    check("div_at6", 32'(md_cnt), 32'd6);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("mult_after_rst", 32'(md_cnt), 32'd5);
    idle(6);

    // Counters: 3 stall cycles and 2 exception cycles after a clean reset
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 0, 0, 1);
    idle(1);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0), 1'($urandom),
          ($urandom_range(0, 3) == 0), 1'($urandom), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 5) == 0));
    end
    idle(2);
    @(negedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles after a mult/multu start.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles after a div/divu start.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port hz_stall  input  1  data-hazard stall request from the D-stage hazard decoder.
REQ-006 SHALL have port D_md_use  input  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-007 SHALL have port E_md_start  input  1  E instruction starts a mult/div this cycle.
REQ-008 SHALL have port E_md_div  input  1  qualifies E_md_start: 1 = div, 0 = mult.
REQ-009 SHALL have port D_eret  input  1  eret decoded in D.
REQ-010 SHALL have port M_exc_req  input  1  exception/interrupt request from CP0.
REQ-011 SHALL have outputs PC_WrEn, FD_WrEn, FD_flush, DE_Stall, Req (output, 1 bit each): pipeline-register controls.
REQ-012 SHALL have port md_busy  output  1  MDU occupied.
REQ-013 SHALL have port md_cnt  output  4  remaining busy cycles.
REQ-014 SHALL have ports stall_cnt (output, 32 bits) and req_cnt (output, 16 bits): performance counters.

Function
REQ-015 SHALL implement MDU FSM states IDLE and BUSY; IDLE->BUSY on accepted start; BUSY->IDLE when md_cnt reaches 0.
REQ-016 SHALL accept a start only when E_md_start=1 and Req=0; load md_cnt with DIV_CYCLES if E_md_div else MULT_CYCLES.
REQ-017 SHALL decrement md_cnt by 1 each cycle in BUSY; a start arriving in BUSY is ignored.
REQ-018 SHALL drive md_busy = (state==BUSY) | (E_md_start & ~Req), combinationally.
REQ-019 SHALL form stall = hz_stall | (D_md_use & md_busy).
REQ-020 SHALL drive Req = M_exc_req combinationally, zero latency.
REQ-021 SHALL, when Req=1, drive PC_WrEn=1, FD_WrEn=1, DE_Stall=0, FD_flush=0; Req overrides stall.
REQ-022 SHALL, when stall=1 and Req=0, drive PC_WrEn=0, FD_WrEn=0, DE_Stall=1 (bubble into E with PC and delay-slot flag held).
REQ-023 SHALL, otherwise, drive PC_WrEn=1, FD_WrEn=1, DE_Stall=0.
REQ-024 SHALL assert FD_flush for exactly the cycle D_eret=1, stall=0 and Req=0; never together with DE_Stall.
REQ-025 SHALL let an in-flight BUSY countdown continue through Req, since the older instruction is committed.
REQ-026 SHALL keep md_cnt within 0..max(MULT_CYCLES, DIV_CYCLES), with no wrap below 0.

Reset
REQ-027 SHALL, on reset, set the FSM to IDLE, md_cnt=0, stall_cnt=0 and req_cnt=0.
REQ-028 SHALL abort any countdown when reset is asserted mid-BUSY; md_busy=0 in the following cycle.
REQ-029 SHALL leave combinational outputs input-driven during reset; the FSM-derived term of md_busy is 0.

Configuration
REQ-030 SHALL, with PIPE_CTRL_PERF_EN defined, increment stall_cnt each cycle stall=1 and Req=0, and increment req_cnt each cycle Req=1.
REQ-031 SHALL make both counters saturate at all-ones.
REQ-032 SHALL, without PIPE_CTRL_PERF_EN, keep both ports present, tie them to 0 and instantiate no counter flops.

Structure
REQ-033 SHALL place the MULT_CYCLES/DIV_CYCLES default constants and the IDLE/BUSY state encodings in the shared def.v package.
REQ-034 SHALL implement the FSM and countdown as one sub-module, md_busy_timer; the remainder is priority logic.

Verification
REQ-035 SHALL cover: start mult (E_md_start=1, E_md_div=0) -> md_cnt 5,4,3,2,1,0 over the next cycles, md_busy 1 throughout, 0 once md_cnt=0.
REQ-036 SHALL cover: div start, then D_md_use=1 held -> DE_Stall=1 and PC_WrEn=0 for 10 cycles, released the cycle md_cnt=0.
REQ-037 SHALL cover: M_exc_req=1 together with E_md_start=1 and hz_stall=1 -> Req=1, PC_WrEn=1, DE_Stall=0; FSM remains IDLE.
REQ-038 SHALL cover: D_eret=1 with hz_stall=1 -> FD_flush=0; the next cycle, hz_stall=0 -> FD_flush=1 for one cycle.
REQ-039 SHALL cover: reset at md_cnt=6 during a div -> md_cnt=0 and md_busy=0 the next cycle; a new mult start then loads 5.
REQ-040 SHALL cover, with PIPE_CTRL_PERF_EN: 3 stall cycles and 2 Req cycles -> stall_cnt=3, req_cnt=2; without the macro both read 0.
